// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle instruction sequencer for the 4-bit-opcode
// datapath. It owns the instruction-cycle FSM, latches the opcode and drives
// every datapath enable, reset and mux select.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (illegal opcodes trap to HALT
// and set a sticky illegal_op flag; otherwise they behave as NOP).
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | post-reset cycle, all datapath resets asserted
// FETCH     | load memory address register from PC
// LATCH     | load IR, increment PC, capture opcode internally
// DECODE    | read register file operands, route by opcode
// EXECUTE   | ALU op / branch / jump / output / memory address setup
// MEM       | hold MEM_WAIT+1 cycles for RAM, STORE writes on the last one
// WRITEBACK | write register file from ALU or RAM
// HALT      | stopped until control_reset
module control_sequencer #(
    parameter int OPCODE_W = 4,
    parameter int MEM_WAIT = 0,
    parameter int RETIRE_W = 16
) (
    input  logic                clock,
    input  logic                control_reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                branch_flag,
    input  logic                lt_flag,
    output logic [2:0]          state,
    output logic [1:0]          alu_control,
    output logic                pc_en,
    output logic                ir_en,
    output logic                read_1_en,
    output logic                read_2_en,
    output logic                reg_file_wr_en,
    output logic                mem_add_en,
    output logic                ram_wr_en,
    output logic                output_en,
    output logic                pc_reset,
    output logic                reg_file_reset,
    output logic                mem_add_reset,
    output logic                output_reset,
    output logic                pc_or_read_mem,
    output logic                pc_in_op,
    output logic                write_reg_from_memory,
    output logic                halted,
    output logic                illegal_op,
    output logic [RETIRE_W-1:0] instr_retired
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_LATCH     = 3'd2,
        S_DECODE    = 3'd3,
        S_EXECUTE   = 3'd4,
        S_MEM       = 3'd5,
        S_WRITEBACK = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_LOAD  = 4'h5;
    localparam logic [3:0] OP_STORE = 4'h6;
    localparam logic [3:0] OP_BEQ   = 4'h7;
    localparam logic [3:0] OP_BLT   = 4'h8;
    localparam logic [3:0] OP_JMP   = 4'h9;
    localparam logic [3:0] OP_OUT   = 4'hA;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // Bits above the 4-bit opcode field; any of them set makes the opcode illegal.
    localparam logic [OPCODE_W-1:0] OP_HI_MASK = ~OPCODE_W'(4'hF);

    state_t                state_q, state_d;
    logic [OPCODE_W-1:0]   op_q, op_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [RETIRE_W-1:0]   retired_q, retired_d;
    logic [3:0]            op_lo;
    logic                  op_illegal;

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic                  illegal_q, illegal_d;
`endif

    assign op_lo         = op_q[3:0];
    assign state         = state_q;
    assign instr_retired = retired_q;

    // Classify the latched opcode as illegal (reserved encodings or high bits set).
    always_comb begin
        op_illegal = |(op_q & OP_HI_MASK);
        if (op_lo inside {4'hB, 4'hC, 4'hD, 4'hE}) begin
            op_illegal = 1'b1;
        end
    end

    // Next-state, datapath control decode, MEM wait timer and retire counter.
    always_comb begin
        state_d               = state_q;
        op_d                  = op_q;
        cnt_d                 = cnt_q;
        retired_d             = retired_q;
        alu_control           = 2'b00;
        pc_en                 = 1'b0;
        ir_en                 = 1'b0;
        read_1_en             = 1'b0;
        read_2_en             = 1'b0;
        reg_file_wr_en        = 1'b0;
        mem_add_en            = 1'b0;
        ram_wr_en             = 1'b0;
        output_en             = 1'b0;
        pc_reset              = 1'b0;
        reg_file_reset        = 1'b0;
        mem_add_reset         = 1'b0;
        output_reset          = 1'b0;
        pc_or_read_mem        = 1'b0;
        pc_in_op              = 1'b0;
        write_reg_from_memory = 1'b0;
        halted                = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal_d             = illegal_q;
`endif

        case (state_q)
            S_IDLE: begin
                pc_reset       = 1'b1;
                reg_file_reset = 1'b1;
                mem_add_reset  = 1'b1;
                output_reset   = 1'b1;
                state_d        = S_FETCH;
            end
            S_FETCH: begin
                mem_add_en = 1'b1;
                state_d    = S_LATCH;
            end
            S_LATCH: begin
                ir_en   = 1'b1;
                pc_en   = 1'b1;
                op_d    = opcode;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                read_1_en = 1'b1;
                read_2_en = 1'b1;
                // Illegal check comes first so a HALT nibble with high bits set
                // is still treated as illegal.
                if (op_illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
`else
                    state_d   = S_FETCH;
`endif
                end else if (op_lo == OP_HALT) begin
                    state_d = S_HALT;
                end else if (op_lo == OP_NOP) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                case (op_lo)
                    OP_ADD: begin
                        alu_control = 2'b00;
                        state_d     = S_WRITEBACK;
                    end
                    OP_SUB: begin
                        alu_control = 2'b01;
                        state_d     = S_WRITEBACK;
                    end
                    OP_AND: begin
                        alu_control = 2'b10;
                        state_d     = S_WRITEBACK;
                    end
                    OP_OR: begin
                        alu_control = 2'b11;
                        state_d     = S_WRITEBACK;
                    end
                    OP_LOAD, OP_STORE: begin
                        mem_add_en     = 1'b1;
                        pc_or_read_mem = 1'b1;
                        cnt_d          = 4'(MEM_WAIT);
                        state_d        = S_MEM;
                    end
                    OP_BEQ: begin
                        alu_control = 2'b01;
                        pc_en       = branch_flag;
                        pc_in_op    = branch_flag;
                    end
                    OP_BLT: begin
                        alu_control = 2'b01;
                        pc_en       = lt_flag;
                        pc_in_op    = lt_flag;
                    end
                    OP_JMP: begin
                        pc_en    = 1'b1;
                        pc_in_op = 1'b1;
                    end
                    OP_OUT: begin
                        output_en = 1'b1;
                    end
                    default: begin
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                if (cnt_q == 4'd0) begin
                    if (op_lo == OP_STORE) begin
                        ram_wr_en = 1'b1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d   = S_WRITEBACK;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WRITEBACK: begin
                reg_file_wr_en        = 1'b1;
                write_reg_from_memory = (op_lo == OP_LOAD);
                state_d               = S_FETCH;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_d == S_FETCH) &&
            (state_q inside {S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK})) begin
            retired_d = retired_q + RETIRE_W'(1);
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

    // State, latched opcode, wait timer and counters with synchronous reset.
    always_ff @(posedge clock) begin
        if (control_reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            cnt_q     <= 4'd0;
            retired_q <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            retired_q <= retired_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Parametrised multi-cycle control unit for the 4-bit-opcode datapath. It owns its instruction-cycle state machine internally instead of taking `state` as an input, and latches the opcode. From the latched opcode, the branch flags and a configurable memory wait count, it generates every register enable, reset and mux select. It sits between the instruction/RAM path and the datapath (PC, register file, ALU, memory address register, output register).

## Interface
Parameters:
- `OPCODE_W`, 4, opcode width (≥4). Any set bit above bit 3 makes the opcode illegal.
- `MEM_WAIT`, 0, extra cycles the MEM state holds for RAM (0–15).
- `RETIRE_W`, 16, width of the retired-instruction counter.

Ports:
- `clock` in 1: single clock, rising edge.
- `control_reset` in 1: synchronous, active-high.
- `opcode` in OPCODE_W: instruction opcode from memory, sampled in LATCH.
- `branch_flag` in 1: ALU equality flag.
- `lt_flag` in 1: ALU less-than flag.
- `state` out 3: current state encoding.
- `alu_control` out 2: 00 add, 01 sub, 10 and, 11 or.
- `pc_en`, `ir_en`, `read_1_en`, `read_2_en`, `reg_file_wr_en`, `mem_add_en`, `ram_wr_en`, `output_en` out 1 each: register/RAM enables.
- `pc_reset`, `reg_file_reset`, `mem_add_reset`, `output_reset` out 1 each: datapath resets.
- `pc_or_read_mem` out 1: memory address source, 0 = PC, 1 = register read.
- `pc_in_op` out 1: PC load source, 0 = increment, 1 = branch target.
- `write_reg_from_memory` out 1: register write source, 1 = RAM, 0 = ALU.
- `halted` out 1: in HALT.
- `illegal_op` out 1: sticky illegal-opcode indicator (see Configuration).
- `instr_retired` out RETIRE_W: count of completed instructions.

## Operation
- States and encodings: IDLE=0, FETCH=1, LATCH=2, DECODE=3, EXECUTE=4, MEM=5, WRITEBACK=6, HALT=7.
- Opcode map, using bits [3:0]:
  - 0000 NOP; 0001 ADD; 0010 SUB; 0011 AND; 0100 OR
  - 0101 LOAD; 0110 STORE; 0111 BEQ; 1000 BLT; 1001 JMP; 1010 OUT; 1111 HALT
  - 1011–1110 are illegal.
- IDLE: all four resets = 1, all other outputs 0. Next state FETCH.
- FETCH: `mem_add_en`=1, `pc_or_read_mem`=0. Next state LATCH.
- LATCH: `ir_en`=1, `pc_en`=1, `pc_in_op`=0. Internal opcode register captures `opcode`. Next state DECODE.
- DECODE: `read_1_en`=`read_2_en`=1. Next state:
  - HALT for HALT.
  - FETCH for NOP.
  - EXECUTE otherwise.
- EXECUTE:
  - ALU ops: `alu_control` from the map. Next state WRITEBACK.
  - LOAD/STORE: `mem_add_en`=1, `pc_or_read_mem`=1. Next state MEM.
  - BEQ: `alu_control`=01; if `branch_flag`, then `pc_en`=1, `pc_in_op`=1. Next state FETCH.
  - BLT: `alu_control`=01; if `lt_flag`, then `pc_en`=1, `pc_in_op`=1. Next state FETCH.
  - JMP: unconditional `pc_en`=1, `pc_in_op`=1. Next state FETCH.
  - OUT: `output_en`=1. Next state FETCH.
  - Flags are sampled combinationally in EXECUTE only.
- MEM: lasts MEM_WAIT+1 cycles, counted by an internal 4-bit down-counter.
  - STORE: `ram_wr_en`=1 on the final MEM cycle only. Next state FETCH.
  - LOAD: next state WRITEBACK.
- WRITEBACK: `reg_file_wr_en`=1; `write_reg_from_memory`=1 for LOAD, 0 for ALU ops. Next state FETCH.
- HALT: `halted`=1, all enables 0. Stays in HALT until `control_reset`.
- `instr_retired` increments by 1 on every transition into FETCH from DECODE, EXECUTE, MEM or WRITEBACK. It wraps modulo 2^RETIRE_W.
- Outputs are decoded from the state register and the latched opcode. An output with no rule for the current state is 0.

## Timing
- `control_reset` sampled high at an edge gives, after that edge: state=IDLE, counter=0, `instr_retired`=0, `illegal_op`=0, latched opcode=0.
- Reset wins over every transition, including mid-MEM and in HALT.
- FETCH follows one cycle after reset deasserts.
- Cycle counts per instruction, FETCH through return to FETCH:
  - NOP: 3.
  - Branch/JMP/OUT: 4.
  - ALU: 5.
  - STORE: 5+MEM_WAIT.
  - LOAD: 6+MEM_WAIT.
- `opcode` must be valid in the LATCH cycle and is ignored elsewhere.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - Illegal opcodes, or any set bit above bit 3, go DECODE→HALT.
  - `illegal_op` is set and held until reset.
  - `instr_retired` does not increment.
- `CTRL_ILLEGAL_TRAP_EN` undefined:
  - Illegal opcodes execute as NOP (DECODE→FETCH, retired count increments).
  - `illegal_op` is tied to 0.

## Test plan
- Reset held 2 cycles, then released → IDLE with all resets=1 for one cycle, then FETCH with `mem_add_en`=1; `instr_retired`=0.
- ADD (0001), then SUB (0010) → each takes 5 cycles; `alu_control` is 00 then 01 in EXECUTE; `reg_file_wr_en`=1 in WRITEBACK; `instr_retired`=2.
- MEM_WAIT=3:
  - STORE (0110) → `ram_wr_en` high for exactly 1 cycle, the 4th MEM cycle; 8 cycles total.
  - LOAD (0101) → WRITEBACK with `write_reg_from_memory`=1; 9 cycles total.
- BEQ with `branch_flag`=1 → `pc_en`=`pc_in_op`=1 in EXECUTE.
- BLT with `lt_flag`=0 → no PC load.
- Opcode 1111 → HALT, `halted`=1, stays there for 20 cycles.
- Reset asserted in the 2nd MEM cycle → IDLE on the next edge with no `ram_wr_en`.
- Opcode 1100:
  - With the macro → HALT, `illegal_op`=1.
  - Without the macro → returns to FETCH after 3 cycles, `instr_retired` incremented.
